task_dispatch_scheduler: RTL

Dispatches incoming tasks to one of the four sub-boards using the per-board free-memory and pending-task status reported by the status detection block. Keeps a shadow copy of each board's status and adjusts it on every dispatch, so back-to-back tasks do not all land on one board between status refreshes. Marks boards offline when their status goes stale. Sits between the host task queue and the sub-board command links.

---
 rtl/task_dispatch_scheduler_if.sv | 31 +++
 rtl/task_dispatch_scheduler.sv | 139 +++++++++++++
 2 files changed

// File: rtl/task_dispatch_scheduler_if.sv
// Host-side bundle of the dispatch scheduler: per-board status, task request and dispatch offer.
interface task_dispatch_scheduler_if;
  logic        status_valid_id0, status_valid_id1, status_valid_id2, status_valid_id3;
  logic [31:0] free_mem_id0, free_mem_id1, free_mem_id2, free_mem_id3;
  logic [31:0] pending_tasks_id0, pending_tasks_id1, pending_tasks_id2, pending_tasks_id3;
  logic        task_req_valid;
  logic [31:0] task_req_mem;
  logic        task_req_ready;
  logic        disp_valid;
  logic [1:0]  disp_board;
  logic [31:0] disp_mem;
  logic        disp_ack;
  logic [3:0]  board_online;
  logic        busy;

  modport master (
    output status_valid_id0, status_valid_id1, status_valid_id2, status_valid_id3,
           free_mem_id0, free_mem_id1, free_mem_id2, free_mem_id3,
           pending_tasks_id0, pending_tasks_id1, pending_tasks_id2, pending_tasks_id3,
           task_req_valid, task_req_mem, disp_ack,
    input  task_req_ready, disp_valid, disp_board, disp_mem, board_online, busy
  );

  modport slave (
    input  status_valid_id0, status_valid_id1, status_valid_id2, status_valid_id3,
           free_mem_id0, free_mem_id1, free_mem_id2, free_mem_id3,
           pending_tasks_id0, pending_tasks_id1, pending_tasks_id2, pending_tasks_id3,
           task_req_valid, task_req_mem, disp_ack,
    output task_req_ready, disp_valid, disp_board, disp_mem, board_online, busy
  );
endinterface

// File: rtl/task_dispatch_scheduler.sv
// Picks a sub-board for each host task from shadowed free-memory / pending-task status,
// adjusting the shadow on every accepted dispatch and dropping boards whose status goes stale.
module task_dispatch_scheduler #(
  parameter int STALE_LIMIT = 1024
) (
  input logic                     clk,
  input logic                     rst_n,
  task_dispatch_scheduler_if.slave bus
);
  localparam int NB = 4;
  localparam int AW = $clog2(STALE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, EVAL, OFFER} state_t;

  state_t              state;
  logic [31:0]         req_mem_q, disp_mem_q;
  logic [1:0]          disp_board_q;
  logic                rdy_q, dv_q, busy_q;

  logic [NB-1:0]       st_vld;
  logic [NB-1:0][31:0] st_free, st_pend;
  logic [NB-1:0][31:0] sh_free, sh_pend;
  logic [NB-1:0]       online;
  logic                ack_fire;

  assign st_vld  = {bus.status_valid_id3, bus.status_valid_id2, bus.status_valid_id1, bus.status_valid_id0};
  assign st_free = {bus.free_mem_id3, bus.free_mem_id2, bus.free_mem_id1, bus.free_mem_id0};
  assign st_pend = {bus.pending_tasks_id3, bus.pending_tasks_id2, bus.pending_tasks_id1, bus.pending_tasks_id0};
  assign ack_fire = dv_q & bus.disp_ack;

  for (genvar i = 0; i < NB; i++) begin : g_board
    logic [31:0]   free_q, pend_q, base_free, base_pend, nxt_free, nxt_pend;
    logic [AW-1:0] age_q;
    logic          on_q;

    // a dispatch landing with a fresh status is charged against the new values
    always_comb begin
      base_free = st_vld[i] ? st_free[i] : free_q;
      base_pend = st_vld[i] ? st_pend[i] : pend_q;
      nxt_free  = base_free;
      nxt_pend  = base_pend;
      if (ack_fire && disp_board_q == 2'(i)) begin
        nxt_free = (base_free >= disp_mem_q) ? base_free - disp_mem_q : '0;
        nxt_pend = (&base_pend) ? base_pend : base_pend + 32'd1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        free_q <= '0;
        pend_q <= '0;
        age_q  <= '0;
        on_q   <= 1'b0;
      end else begin
        free_q <= nxt_free;
        pend_q <= nxt_pend;
        if (st_vld[i]) begin
          age_q <= '0;
          on_q  <= 1'b1;
        end else if (age_q != AW'(STALE_LIMIT)) begin
          age_q <= age_q + 1'b1;
          if (age_q == AW'(STALE_LIMIT - 1)) on_q <= 1'b0;
        end
      end
    end

    assign sh_free[i] = free_q;
    assign sh_pend[i] = pend_q;
    assign online[i]  = on_q;
  end

  // fewest pending, then most free memory; strict compares keep the lowest index on full ties
  logic        found;
  logic [1:0]  sel;
  logic [31:0] best_pend, best_free;
  always_comb begin
    found     = 1'b0;
    sel       = '0;
    best_pend = '1;
    best_free = '0;
    for (int i = 0; i < NB; i++) begin
      if (online[i] && sh_free[i] >= req_mem_q) begin
        if (!found || sh_pend[i] < best_pend ||
            (sh_pend[i] == best_pend && sh_free[i] > best_free)) begin
          found     = 1'b1;
          sel       = 2'(i);
          best_pend = sh_pend[i];
          best_free = sh_free[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      req_mem_q    <= '0;
      disp_board_q <= '0;
      disp_mem_q   <= '0;
      rdy_q        <= 1'b1;
      dv_q         <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.task_req_valid) begin
          req_mem_q <= bus.task_req_mem;
          state     <= EVAL;
          rdy_q     <= 1'b0;
          busy_q    <= 1'b1;
        end
        EVAL: if (found) begin
          disp_board_q <= sel;
          disp_mem_q   <= req_mem_q;
          state        <= OFFER;
          dv_q         <= 1'b1;
        end
        OFFER: if (bus.disp_ack) begin
          state  <= IDLE;
          dv_q   <= 1'b0;
          rdy_q  <= 1'b1;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          dv_q   <= 1'b0;
          rdy_q  <= 1'b1;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.task_req_ready = rdy_q;
  assign bus.disp_valid     = dv_q;
  assign bus.busy           = busy_q;
  assign bus.disp_board     = disp_board_q;
  assign bus.disp_mem       = disp_mem_q;
  assign bus.board_online   = online;
endmodule
